// File: rtl/if_pc_gen_pkg.sv
// -----------------------------------------------------------------------------
// if_pc_gen_pkg
// Shared widths, reset address, BTB geometry and helper functions for the
// instruction-fetch PC generator. The build-time macros PC_WIDTH, WORD_WIDTH
// and RESET_PC are defined here with defaults; the rest of the design uses
// the package localparams derived from them.
// Optional feature macro: IF_PC_GEN_BTB_EN (branch target buffer enable),
// consumed by if_pc_gen.sv.
// No ports (package).
// -----------------------------------------------------------------------------
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef RESET_PC
`define RESET_PC 32'h0000_0000
`endif

package if_pc_gen_pkg;

  localparam int PC_WIDTH   = `PC_WIDTH;
  localparam int WORD_WIDTH = `WORD_WIDTH;
  localparam logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(`RESET_PC);

  // Direct-mapped BTB: index taken from word-address bits, tag is the rest.
  localparam int BTB_DEPTH   = 16;
  localparam int BTB_IDX_W   = 4;
  localparam int BTB_IDX_LSB = 2;
  localparam int BTB_TAG_LSB = BTB_IDX_LSB + BTB_IDX_W;
  localparam int BTB_TAG_W   = PC_WIDTH - BTB_TAG_LSB;

  typedef logic [1:0] ctr_t;
  localparam ctr_t CTR_WEAK_NT = 2'b01;  // reset value
  localparam ctr_t CTR_WEAK_T  = 2'b10;  // value on allocation

  // Fetch addresses are word aligned; any loaded address has [1:0] cleared.
  function automatic logic [PC_WIDTH-1:0] pc_align(input logic [PC_WIDTH-1:0] a);
    return {a[PC_WIDTH-1:2], 2'b00};
  endfunction

  // 2-bit saturating counter step.
  function automatic ctr_t ctr_step(input ctr_t c, input logic taken);
    ctr_t r;
    r = c;
    if (taken && c != 2'b11) r = c + 2'd1;
    else if (!taken && c != 2'b00) r = c - 2'd1;
    return r;
  endfunction

endpackage

// File: rtl/if_pc_gen_if.sv
// -----------------------------------------------------------------------------
// if_pc_gen_if
// Bundles the pipeline-control, branch-resolution and fetch-output signals of
// if_pc_gen. The master side (pipeline/EX stage) drives control and branch
// resolution; the slave side (if_pc_gen) drives pc, predt_br_taken, if_flush.
//   cpu_en, pc_stall, ex_redirect, ex_redirect_pc,
//   ex_br_valid, ex_br_pc, ex_br_taken, ex_br_target   : master -> slave
//   pc, predt_br_taken, if_flush                       : slave -> master
// -----------------------------------------------------------------------------
interface if_pc_gen_if;
  import if_pc_gen_pkg::*;

  logic                cpu_en;
  logic                pc_stall;
  logic                ex_redirect;
  logic [PC_WIDTH-1:0] ex_redirect_pc;
  logic                ex_br_valid;
  logic [PC_WIDTH-1:0] ex_br_pc;
  logic                ex_br_taken;
  logic [PC_WIDTH-1:0] ex_br_target;
  logic [PC_WIDTH-1:0] pc;
  logic                predt_br_taken;
  logic                if_flush;

  modport master (
    output cpu_en, pc_stall, ex_redirect, ex_redirect_pc,
           ex_br_valid, ex_br_pc, ex_br_taken, ex_br_target,
    input  pc, predt_br_taken, if_flush
  );

  modport slave (
    input  cpu_en, pc_stall, ex_redirect, ex_redirect_pc,
           ex_br_valid, ex_br_pc, ex_br_taken, ex_br_target,
    output pc, predt_br_taken, if_flush
  );
endinterface

// File: rtl/if_pc_gen_btb.sv
// -----------------------------------------------------------------------------
// if_btb
// 16-entry direct-mapped branch target buffer with 2-bit saturating counters.
// Lookup is combinational on lkp_pc_i; update is registered on the clock
// edge, so a lookup of an entry being updated sees its pre-update contents.
// Ports:
//   clk, rst_n       clock / asynchronous active-low reset
//   lkp_pc_i         fetch address to look up
//   lkp_taken_o      hit && counter MSB
//   lkp_target_o     stored target of the indexed entry
//   upd_en_i         resolved branch present (already qualified by cpu_en)
//   upd_pc_i         address of the resolved branch
//   upd_taken_i      actual direction
//   upd_target_i     actual taken target
// -----------------------------------------------------------------------------
module if_btb
  import if_pc_gen_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PC_WIDTH-1:0] lkp_pc_i,
  output logic                lkp_taken_o,
  output logic [PC_WIDTH-1:0] lkp_target_o,
  input  logic                upd_en_i,
  input  logic [PC_WIDTH-1:0] upd_pc_i,
  input  logic                upd_taken_i,
  input  logic [PC_WIDTH-1:0] upd_target_i
);

  logic                 valid_q  [BTB_DEPTH];
  logic [BTB_TAG_W-1:0] tag_q    [BTB_DEPTH];
  logic [PC_WIDTH-1:0]  target_q [BTB_DEPTH];
  ctr_t                 ctr_q    [BTB_DEPTH];

  logic [BTB_IDX_W-1:0] lkp_idx;
  logic [BTB_TAG_W-1:0] lkp_tag;
  logic [BTB_IDX_W-1:0] upd_idx;
  logic [BTB_TAG_W-1:0] upd_tag;
  logic                 lkp_hit;
  logic                 upd_hit;
  ctr_t                 upd_ctr_d;

  assign lkp_idx = lkp_pc_i[BTB_TAG_LSB-1:BTB_IDX_LSB];
  assign lkp_tag = lkp_pc_i[PC_WIDTH-1:BTB_TAG_LSB];
  assign upd_idx = upd_pc_i[BTB_TAG_LSB-1:BTB_IDX_LSB];
  assign upd_tag = upd_pc_i[PC_WIDTH-1:BTB_TAG_LSB];

  assign lkp_hit      = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
  assign lkp_taken_o  = lkp_hit && ctr_q[lkp_idx][1];
  assign lkp_target_o = target_q[lkp_idx];

  assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_ctr_d = upd_hit ? ctr_step(ctr_q[upd_idx], upd_taken_i) : CTR_WEAK_T;

  // One register set per entry; only the indexed entry reacts to an update.
  // A not-taken miss leaves everything untouched (no allocation).
  generate
    for (genvar gi = 0; gi < BTB_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q[gi]  <= 1'b0;
          tag_q[gi]    <= '0;
          target_q[gi] <= '0;
          ctr_q[gi]    <= CTR_WEAK_NT;
        end else if (upd_en_i && (upd_idx == BTB_IDX_W'(gi)) && (upd_hit || upd_taken_i)) begin
          ctr_q[gi] <= upd_ctr_d;
          if (upd_taken_i) begin
            valid_q[gi]  <= 1'b1;
            tag_q[gi]    <= upd_tag;
            target_q[gi] <= upd_target_i;
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/if_pc_gen.sv
// -----------------------------------------------------------------------------
// if_pc_gen
// Fetch-address generator. Holds the pc register and selects the next fetch
// address with priority: cpu_en low (hold) > EX redirect > stall (hold) >
// predicted-taken BTB target > pc + 4. if_flush mirrors ex_redirect.
// Optional feature macro IF_PC_GEN_BTB_EN: when defined an if_btb predictor
// is instantiated; when undefined predt_br_taken is 0, ex_br_* are ignored
// and sequential fetch is always pc + 4.
// Ports:
//   clk    pipeline clock, rising edge
//   rst_n  asynchronous active-low reset (pc <- RESET_PC, BTB cleared)
//   bus    if_pc_gen_if.slave (control, branch resolution, pc outputs)
// -----------------------------------------------------------------------------
module if_pc_gen
  import if_pc_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  if_pc_gen_if.slave  bus
);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;
  logic [PC_WIDTH-1:0] pc_seq;
  logic                predt_taken;

`ifdef IF_PC_GEN_BTB_EN
  logic [PC_WIDTH-1:0] btb_target;

  if_btb u_btb (
    .clk          (clk),
    .rst_n        (rst_n),
    .lkp_pc_i     (pc_q),
    .lkp_taken_o  (predt_taken),
    .lkp_target_o (btb_target),
    .upd_en_i     (bus.cpu_en && bus.ex_br_valid),
    .upd_pc_i     (bus.ex_br_pc),
    .upd_taken_i  (bus.ex_br_taken),
    .upd_target_i (bus.ex_br_target)
  );

  assign pc_seq = predt_taken ? pc_align(btb_target) : pc_q + PC_WIDTH'(4);
`else
  assign predt_taken = 1'b0;
  assign pc_seq      = pc_q + PC_WIDTH'(4);
`endif

  // A redirect outranks a stall: the stalled instruction is on the wrong path.
  always_comb begin
    pc_d = pc_q;
    if (!bus.cpu_en) begin
      pc_d = pc_q;
    end else if (bus.ex_redirect) begin
      pc_d = pc_align(bus.ex_redirect_pc);
    end else if (bus.pc_stall) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_seq;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= pc_align(RESET_PC);
    else        pc_q <= pc_d;
  end

  assign bus.pc             = pc_q;
  assign bus.predt_br_taken = predt_taken;
  assign bus.if_flush       = bus.ex_redirect;

endmodule

// File: tb/tb_if_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_if_pc_gen
// Each cycle the stimulus process applies inputs, pushes the outputs a
// reference model predicts for that cycle into a queue, then advances the
// model. An independent monitor pops one entry per falling edge and compares.
// The model is built with IF_PC_GEN_BTB_EN in the same state as the design.
// -----------------------------------------------------------------------------
module tb_if_pc_gen;
  import if_pc_gen_pkg::*;

  localparam int W = PC_WIDTH;
`ifdef IF_PC_GEN_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;

  if_pc_gen_if bus ();

  if_pc_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] pc;
    logic         pred;
    logic         flush;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // ---------------- reference model (behavioural) ----------------
  logic [W-1:0] m_pc;
  logic [W-1:0] m_tag [int];
  logic [W-1:0] m_tgt [int];
  int           m_ctr [int];

  function automatic int m_index(input logic [W-1:0] a);
    return int'((a / 4) % 16);
  endfunction

  function automatic logic [W-1:0] m_tagof(input logic [W-1:0] a);
    return a / 64;
  endfunction

  function automatic bit m_predict(input logic [W-1:0] a, output logic [W-1:0] t);
    int i;
    i = m_index(a);
    t = '0;
    if (!BTB_ON) return 1'b0;
    if (!m_tag.exists(i)) return 1'b0;
    if (m_tag[i] != m_tagof(a)) return 1'b0;
    t = m_tgt[i];
    return m_ctr[i] >= 2;
  endfunction

  task automatic m_reset();
    m_pc = RESET_PC & ~W'(3);
    m_tag.delete();
    m_tgt.delete();
    m_ctr.delete();
  endtask

  task automatic m_step(input bit en, input bit stall, input bit redir,
                        input logic [W-1:0] rpc, input bit bv,
                        input logic [W-1:0] bpc, input bit bt,
                        input logic [W-1:0] btgt);
    logic [W-1:0] t;
    bit p;
    int i;
    if (!en) return;
    p = m_predict(m_pc, t);           // decision uses pre-update predictor
    if (BTB_ON && bv) begin
      i = m_index(bpc);
      if (m_tag.exists(i) && m_tag[i] == m_tagof(bpc)) begin
        m_ctr[i] = bt ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                      : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
        if (bt) m_tgt[i] = btgt;
      end else if (bt) begin
        m_tag[i] = m_tagof(bpc);
        m_tgt[i] = btgt;
        m_ctr[i] = 2;
      end
    end
    if (redir)      m_pc = rpc & ~W'(3);
    else if (stall) m_pc = m_pc;
    else if (p)     m_pc = t & ~W'(3);
    else            m_pc = m_pc + W'(4);
  endtask

  // ---------------- stimulus ----------------
  task automatic cyc(input string name, input bit rst, input bit en, input bit stall,
                     input bit redir, input logic [W-1:0] rpc,
                     input bit bv, input logic [W-1:0] bpc, input bit bt,
                     input logic [W-1:0] btgt,
                     input bit use_const, input logic [W-1:0] cpc, input bit cpred);
    exp_t e;
    logic [W-1:0] t;
    @(posedge clk);
    #2;
    rst_n              = ~rst;
    bus.cpu_en         = en;
    bus.pc_stall       = stall;
    bus.ex_redirect    = redir;
    bus.ex_redirect_pc = rpc;
    bus.ex_br_valid    = bv;
    bus.ex_br_pc       = bpc;
    bus.ex_br_taken    = bt;
    bus.ex_br_target   = btgt;
    if (rst) m_reset();
    e.name  = name;
    e.flush = redir;
    if (use_const) begin
      e.pc   = cpc;
      e.pred = cpred;
    end else begin
      e.pc   = m_pc;
      e.pred = m_predict(m_pc, t);
    end
    exp_q.push_back(e);
    if (!rst) m_step(en, stall, redir, rpc, bv, bpc, bt, btgt);
  endtask

  task automatic run(input string name, input logic [W-1:0] cpc, input bit cpred);
    cyc(name, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1, cpc, cpred);
  endtask

  function automatic logic [W-1:0] pick_addr();
    case ($urandom_range(0, 5))
      0:       return W'(32'h40);
      1:       return W'(32'h80);
      2:       return W'(32'h1040);
      3:       return W'(32'h44);
      4:       return W'(32'h100);
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- monitor ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".pc"},    bus.pc, e.pc);
        check({e.name, ".pred"},  W'(bus.predt_br_taken), W'(e.pred));
        check({e.name, ".flush"}, W'(bus.if_flush), W'(e.flush));
        $display("[%0t] %s pc=%h pred=%b flush=%b", $time, e.name,
                 bus.pc, bus.predt_br_taken, bus.if_flush);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [W-1:0] hit_pc;
    logic [W-1:0] after_hit;
    rst_n              = 1'b0;
    bus.cpu_en         = 1'b1;
    bus.pc_stall       = 1'b0;
    bus.ex_redirect    = 1'b0;
    bus.ex_redirect_pc = '0;
    bus.ex_br_valid    = 1'b0;
    bus.ex_br_pc       = '0;
    bus.ex_br_taken    = 1'b0;
    bus.ex_br_target   = '0;
    m_reset();

    hit_pc    = BTB_ON ? W'(32'h80) : W'(32'h44);
    after_hit = W'(32'h104C);

    // reset state, then free run
    cyc("reset", 1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b1, W'(32'h40), 1'b1, W'(32'h80),
        1'b1, W'(32'h0), 1'b0);
    run("run0", W'(32'h0), 1'b0);
    run("run4", W'(32'h4), 1'b0);
    // stall at 0x8, redirect overrides stall in the second cycle
    cyc("stall1", 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1, W'(32'h8), 1'b0);
    cyc("stall_redir", 1'b0, 1'b1, 1'b1, 1'b1, W'(32'h100), 1'b0, '0, 1'b0, '0,
        1'b1, W'(32'h8), 1'b0);
    // taken branch at 0x40 -> 0x80 trains the BTB
    cyc("train", 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1, W'(32'h40), 1'b1, W'(32'h80),
        1'b1, W'(32'h100), 1'b0);
    cyc("go40", 1'b0, 1'b1, 1'b0, 1'b1, W'(32'h40), 1'b0, '0, 1'b0, '0,
        1'b1, W'(32'h104), 1'b0);
    run("fetch40", W'(32'h40), BTB_ON);
    cyc("go1040", 1'b0, 1'b1, 1'b0, 1'b1, W'(32'h1040), 1'b0, '0, 1'b0, '0,
        1'b1, hit_pc, 1'b0);
    run("alias1040", W'(32'h1040), 1'b0);
    // two not-taken resolutions weaken the entry to 00
    cyc("nt1", 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1, W'(32'h40), 1'b0, W'(32'h80),
        1'b1, W'(32'h1044), 1'b0);
    cyc("nt2", 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1, W'(32'h40), 1'b0, W'(32'h80),
        1'b1, W'(32'h1048), 1'b0);
    cyc("go40b", 1'b0, 1'b1, 1'b0, 1'b1, W'(32'h40), 1'b0, '0, 1'b0, '0,
        1'b1, after_hit, 1'b0);
    run("fetch40nt", W'(32'h40), 1'b0);
    run("seq44", W'(32'h44), 1'b0);
    // wrap at the top of the address space; unaligned redirect bits dropped
    cyc("gotop", 1'b0, 1'b1, 1'b0, 1'b1, W'(32'hFFFF_FFFF), 1'b0, '0, 1'b0, '0,
        1'b1, W'(32'h48), 1'b0);
    run("top", W'(32'hFFFF_FFFC), 1'b0);
    run("wrap", W'(32'h0), 1'b0);
    // cpu_en low freezes pc even with a redirect; flush still follows redirect
    cyc("freeze", 1'b0, 1'b0, 1'b0, 1'b1, W'(32'h200), 1'b1, W'(32'h4), 1'b1, W'(32'h300),
        1'b1, W'(32'h4), 1'b0);
    run("thawed", W'(32'h4), 1'b0);

    // randomized phase against the model (includes occasional mid-update reset)
    for (int i = 0; i < 500; i++) begin
      cyc("rand", ($urandom_range(0, 149) == 0), ($urandom_range(0, 7) != 0),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), pick_addr(),
          1'($urandom_range(0, 1)), pick_addr(), 1'($urandom_range(0, 1)), pick_addr(),
          1'b0, '0, 1'b0);
    end
    cyc("final", 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);

    @(negedge clk);
    #1;
    check("queue_drained", W'(exp_q.size()), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
